// File: rtl/rv32i_regfile_rdctrl_pkg.sv
// Shared definitions for the register-file read sequencer: width defaults,
// FSM state encoding and the capture-select encoding.
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

package rv32i_regfile_rdctrl_pkg;

  localparam int unsigned XLEN_DEF    = 32;
  localparam int unsigned RADDR_W_DEF = `REG_ADDR_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE1 = 3'd1,
    ST_ISSUE2 = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_VALID  = 3'd4
  } rd_state_e;

  // Which operand register takes ram_rdata in the cycle after a read issue.
  typedef enum logic [1:0] {
    CAP_NONE = 2'd0,
    CAP_RS1  = 2'd1,
    CAP_RS2  = 2'd2
  } cap_sel_e;

  // States in which an already-issued read may be overtaken by a writeback.
  function automatic logic fwd_window(input rd_state_e s);
    return (s == ST_ISSUE2) || (s == ST_DRAIN) || (s == ST_VALID);
  endfunction

endpackage

// File: rtl/rv32i_opr_fwd_reg.sv
// One held operand: cleared on request accept when unused, loaded from the
// RAM read port on capture, and overwritten by a matching writeback.
module rv32i_opr_fwd_reg
  import rv32i_regfile_rdctrl_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr_i,
  input  logic               cap_en_i,
  input  logic [XLEN-1:0]    cap_data_i,
  input  logic [RADDR_W-1:0] src_addr_i,
  input  logic               fwd_en_i,
  input  logic [RADDR_W-1:0] fwd_addr_i,
  input  logic [XLEN-1:0]    fwd_data_i,
  output logic [XLEN-1:0]    data_o
);

  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] data_d;
  logic            fwd_hit;

  assign fwd_hit = fwd_en_i && (fwd_addr_i == src_addr_i);

  // Forwarded data is newer than the RAM read, so it beats a same-cycle capture.
  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = '0;
    end else if (fwd_hit) begin
      data_d = fwd_data_i;
    end else if (cap_en_i) begin
      data_d = cap_data_i;
    end
  end

  // Operand storage register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/rv32i_regfile_rdctrl.sv
// Serialises rs1/rs2 reads onto a single-port register RAM, gives writebacks
// priority on the port, and hands both operands to execute via valid/ready.
module rv32i_regfile_rdctrl
  import rv32i_regfile_rdctrl_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned RADDR_W = RADDR_W_DEF
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               dec_valid_i,
  output logic               dec_ready_o,
  input  logic [RADDR_W-1:0] rs1_addr_i,
  input  logic [RADDR_W-1:0] rs2_addr_i,
  input  logic               rs1_re_i,
  input  logic               rs2_re_i,
  input  logic               wb_valid_i,
  input  logic [RADDR_W-1:0] wb_addr_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic               ram_en_o,
  output logic               ram_we_o,
  output logic [RADDR_W-1:0] ram_addr_o,
  output logic [XLEN-1:0]    ram_wdata_o,
  input  logic [XLEN-1:0]    ram_rdata_i,
  output logic               opr_valid_o,
  input  logic               opr_ready_i,
  output logic [XLEN-1:0]    rs1_data_o,
  output logic [XLEN-1:0]    rs2_data_o
);

  rd_state_e          state_q, state_d;
  cap_sel_e           cap_sel_q, cap_sel_d;
  logic               dec_ready_q;
  logic [RADDR_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [RADDR_W-1:0] rs2_addr_q, rs2_addr_d;
  logic               need1_q, need1_d;
  logic               need2_q, need2_d;
  logic               iss1_q, iss1_d;
  logic               iss2_q, iss2_d;

  logic               accept;
  logic               wb_act;
  logic               rd_issue;
  logic [RADDR_W-1:0] rd_addr;
  logic [1:0]         clr_v;
  logic [1:0]         cap_v;
  logic [1:0]         fwd_v;
  logic [1:0]         iss_v;
  logic [RADDR_W-1:0] src_addr_v [2];
  logic [XLEN-1:0]    opr_v [2];

  assign accept = dec_valid_i && dec_ready_q && (state_q == ST_IDLE);
  // Writes to x0 never reach the RAM and never stall or forward.
  assign wb_act = wb_valid_i && (wb_addr_i != '0);

  // Next-state, request latch and read-issue decisions.
  always_comb begin
    state_d    = state_q;
    cap_sel_d  = CAP_NONE;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    need1_d    = need1_q;
    need2_d    = need2_q;
    iss1_d     = iss1_q;
    iss2_d     = iss2_q;
    rd_issue   = 1'b0;
    rd_addr    = '0;
    clr_v      = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rs1_addr_d = rs1_addr_i;
          rs2_addr_d = rs2_addr_i;
          need1_d    = rs1_re_i && (rs1_addr_i != '0);
          need2_d    = rs2_re_i && (rs2_addr_i != '0);
          iss1_d     = 1'b0;
          iss2_d     = 1'b0;
          clr_v[0]   = !need1_d;
          clr_v[1]   = !need2_d;
          if (need1_d) begin
            state_d = ST_ISSUE1;
          end else if (need2_d) begin
            state_d = ST_ISSUE2;
          end else begin
            state_d = ST_VALID;
          end
        end
      end
      ST_ISSUE1: begin
        if (!wb_act) begin
          rd_issue  = 1'b1;
          rd_addr   = rs1_addr_q;
          cap_sel_d = CAP_RS1;
          iss1_d    = 1'b1;
          state_d   = need2_q ? ST_ISSUE2 : ST_DRAIN;
        end
      end
      ST_ISSUE2: begin
        if (!wb_act) begin
          rd_issue  = 1'b1;
          rd_addr   = rs2_addr_q;
          cap_sel_d = CAP_RS2;
          iss2_d    = 1'b1;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_VALID;
      end
      ST_VALID: begin
        if (opr_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers; reset discards any pending capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      cap_sel_q   <= CAP_NONE;
      dec_ready_q <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      need1_q     <= 1'b0;
      need2_q     <= 1'b0;
      iss1_q      <= 1'b0;
      iss2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cap_sel_q   <= cap_sel_d;
      dec_ready_q <= (state_d == ST_IDLE);
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      need1_q     <= need1_d;
      need2_q     <= need2_d;
      iss1_q      <= iss1_d;
      iss2_q      <= iss2_d;
    end
  end

  // RAM port: a writeback owns the port; otherwise a read may be issued.
  always_comb begin
    ram_en_o    = wb_act || rd_issue;
    ram_we_o    = wb_act;
    ram_addr_o  = wb_act ? wb_addr_i : rd_addr;
    ram_wdata_o = wb_data_i;
  end

  assign iss_v[0]      = iss1_q;
  assign iss_v[1]      = iss2_q;
  assign cap_v[0]      = (cap_sel_q == CAP_RS1);
  assign cap_v[1]      = (cap_sel_q == CAP_RS2);
  assign src_addr_v[0] = rs1_addr_q;
  assign src_addr_v[1] = rs2_addr_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_opr
      // Only operands whose read is already in flight or done can go stale.
      assign fwd_v[gi] = wb_act && iss_v[gi] && fwd_window(state_q);

      rv32i_opr_fwd_reg #(
        .XLEN    (XLEN),
        .RADDR_W (RADDR_W)
      ) u_opr (
        .clk        (clk),
        .rstn       (rstn),
        .clr_i      (clr_v[gi]),
        .cap_en_i   (cap_v[gi]),
        .cap_data_i (ram_rdata_i),
        .src_addr_i (src_addr_v[gi]),
        .fwd_en_i   (fwd_v[gi]),
        .fwd_addr_i (wb_addr_i),
        .fwd_data_i (wb_data_i),
        .data_o     (opr_v[gi])
      );
    end
  endgenerate

  assign dec_ready_o = dec_ready_q;
  assign opr_valid_o = (state_q == ST_VALID);
  assign rs1_data_o  = opr_v[0];
  assign rs2_data_o  = opr_v[1];

endmodule

// File: doc/rv32i_regfile_rdctrl.md
# rv32i_regfile_rdctrl

Sequencer that sits between the RV32I instruction decoder and a single-port integer register RAM (one access per cycle, read or write, 1-cycle registered read). It accepts a decoded rs1/rs2 read request, serialises the two reads onto the RAM port, and interleaves writeback writes, which always have priority. It returns both operands to the execute stage over a valid/ready handshake. Held operands are kept coherent with later writebacks by forwarding.

## Interface
Parameters:
- XLEN, 32, data width of a register
- RADDR_W, `REG_ADDR_WIDTH (5), register address width

Ports (clock and reset first):
- clk  in  1  sole clock, rising edge
- rstn  in  1  asynchronous, active-low reset
- dec_valid_i  in  1  decoder request valid
- dec_ready_o  out  1  request accepted when high with dec_valid_i
- rs1_addr_i, rs2_addr_i  in  RADDR_W  source addresses
- rs1_re_i, rs2_re_i  in  1  source read enables
- wb_valid_i  in  1  writeback write; always accepted, no ready
- wb_addr_i  in  RADDR_W  writeback address
- wb_data_i  in  XLEN  writeback data
- ram_en_o  out  1  RAM access this cycle
- ram_we_o  out  1  1 = write, 0 = read
- ram_addr_o  out  RADDR_W  RAM address
- ram_wdata_o  out  XLEN  RAM write data
- ram_rdata_i  in  XLEN  RAM read data, valid the cycle after a read issue
- opr_valid_o  out  1  operands valid
- opr_ready_i  in  1  execute stage accepts operands
- rs1_data_o, rs2_data_o  out  XLEN  operands

## Operation
- FSM states are IDLE, ISSUE1, ISSUE2, DRAIN, VALID. The FSM is registered. dec_ready_o = (state == IDLE), registered.
- IDLE, on dec_valid_i:
  - Latch both addresses and enables.
  - Set need1 = rs1_re_i && rs1_addr_i != 0. Set need2 likewise for rs2.
  - Clear any operand not needed to 0.
  - Next state: ISSUE1 if need1; else ISSUE2 if need2; else VALID.
- ISSUE1 / ISSUE2:
  - If wb_valid_i is high, perform the write and stay in the state (stall).
  - Otherwise issue a read of rs1 or rs2.
  - After ISSUE1 the next state is ISSUE2 if need2, else DRAIN. After ISSUE2 the next state is DRAIN.
- DRAIN: the last outstanding read returns; next state VALID.
- VALID: opr_valid_o = 1. On opr_ready_i, go to IDLE. A new request can be accepted no earlier than the following cycle.
- Capture: a registered flag cap_sel ∈ {none, rs1, rs2} is set on each read issue. In the next cycle, ram_rdata_i is written into the selected operand register, in any state.
- Writeback:
  - Writes to x0 are dropped: no RAM access, no forwarding.
  - Otherwise drive ram_en_o = ram_we_o = 1 with the address and data.
- Forwarding: a write at cycle t updates every operand register whose read was issued before t, when the address matches.
  - This applies in states ISSUE2, DRAIN and VALID.
  - In a capture cycle with a matching write, wb_data_i wins over ram_rdata_i.
  - Reads issued after a write see the written value through the RAM.
- When no read or write is issued, ram_en_o = 0 and ram_we_o = 0. ram_addr_o and ram_wdata_o are don't-care.
- Arithmetic: none; all paths are selection only.

## Timing
- Reset values: state = IDLE, dec_ready_o = 0 (rises at the first clk edge after release), opr_valid_o = 0, rs1_data_o = rs2_data_o = 0, cap_sel = none, ram_en_o = ram_we_o = 0.
- Latency without writeback stalls, with accept at edge T:
  - Two reads: opr_valid_o is high at T+4.
  - One read: T+3.
  - No reads (x0 or disabled): T+1.
- Each writeback cycle during ISSUE1/ISSUE2 adds one cycle. Continuous writeback starves reads; this is accepted by design.
- Reset mid-operation: immediate return to IDLE. The pending capture is discarded and the held operands are cleared.
- opr_valid_o stays high and the operands stay stable while opr_ready_i is low, except for forwarding updates.

## Structure
- State encoding, the cap_sel encoding and the XLEN/RADDR_W defaults belong in the shared macro header next to `REG_ADDR_WIDTH.
- One sub-module, rv32i_opr_fwd_reg: an operand register with a capture port, a forward-compare port and a clear. It is instantiated twice, for rs1 and rs2.
- The FSM and RAM port mux are inline in rv32i_regfile_rdctrl.

## Test plan
- RAM preloaded x3=0x11, x7=0x22. Request rs1=3, rs2=7. Expect reads of 3 then 7 on consecutive cycles, then opr_valid_o at T+4 with rs1_data_o=0x11, rs2_data_o=0x22.
- Request rs1=0, rs2_re_i=0. Expect no RAM access, opr_valid_o at T+1, both operands 0.
- wb_valid_i to x5=0xAB during ISSUE1 of a request rs1=5. Expect the write first, a one-cycle stall, then the read returns 0xAB.
- Request rs1=9 (RAM 0x1). A write to x9=0x2 occurs in the DRAIN cycle, and a write to x9=0x3 occurs while in VALID with opr_ready_i=0. Expect rs1_data_o=0x3 when opr_ready_i rises.
- Write to x0=0xFF. Expect ram_en_o=0; a later read of x0 gives 0.
- Assert rstn low during ISSUE2. Expect all outputs at reset values. The following request completes normally with no stale capture.
